ntt_stream_feeder: RTL and testbench
====================================

// Module: ntt_stream_feeder
// PURPOSE
//  Upstream stage of ntt_core. Splits a 256-bit coefficient bus into 4 per-lane FIFOs.
//  Each FIFO presents the 65-bit dout/empty_n/read stream interface, plus a peek view,
//  matching core_istreams_0..3 and core_istreams_peek_0..3. Bit 64 of each stream word
//  is the end-of-transmission (EoT) flag. Bits 63:0 hold two 32-bit residues mod q.
// PARAMETERS
//  LANES           4    stream lanes; fixed at 4, matching ntt_core
//  DATA_W          64   payload bits per lane; stream word is DATA_W+1 bits
//  FIFO_DEPTH      8    entries per lane FIFO; power of two, >=2
//  WORDS_PER_POLY  128  input words per transform (N=1024 / (4 lanes * 2 coeffs))
// PORTS
//  clk                 in   1    single clock
//  reset               in   1    synchronous, active-high
//  start               in   1    1-cycle pulse; honoured only in IDLE
//  num_polys           in   32   transforms to stream; sampled on start
//  busy                out  1    1 when state != IDLE
//  done                out  1    1-cycle pulse after EoT is pushed on all lanes
//  in_data             in   256  lane i payload = in_data[64*i+63 : 64*i]
//  in_valid            in   1    upstream word valid
//  in_ready            out  1    feeder accepts the word this cycle
//  core_istreams_i_dout         out 65 FIFO head, i=0..3
//  core_istreams_i_empty_n      out 1  FIFO i non-empty
//  core_istreams_i_read         in  1  pop FIFO i
//  core_istreams_peek_i_dout    out 65 equal to core_istreams_i_dout
//  core_istreams_peek_i_empty_n out 1  equal to core_istreams_i_empty_n
//  core_istreams_peek_i_read    in  1  ignored; peek never pops
// BEHAVIOUR
//  Reset: state=IDLE, all FIFOs flushed, empty_n=0, dout=0, in_ready=0, busy=0, done=0,
//   and counters cleared. Reset mid-stream discards all buffered words and aborts.
//  space = every lane FIFO has occupancy < FIFO_DEPTH.
//   Occupancy is the registered count; a same-cycle pop gives no push credit.
//  FSM states:
//   IDLE:   on start, latch total = num_polys*WORDS_PER_POLY (32-bit, wraps mod 2^32).
//           Clear wcnt. Go to STREAM, or straight to EOT if total==0.
//   STREAM: in_ready = space. On in_valid&&in_ready, push {1'b0, lane payload} to all
//           4 FIFOs in lockstep and increment wcnt. Go to EOT when wcnt+1==total.
//   EOT:    in_ready=0. When space, push {1'b1, 64'd0} to all lanes, then go to DONE.
//   DONE:   done=1 for one cycle, then return to IDLE.
//  start outside IDLE is ignored. in_valid outside STREAM is ignored; the word is not consumed.
//  in_ready depends only on registered state, never on in_valid.
//  Latency: a word accepted at edge t has empty_n=1 with that word on dout after edge t.
//   This holds for an empty FIFO. There is no combinational in->out bypass.
//  read while empty_n=0 is ignored. Occupancy never underflows.
//  Simultaneous push and pop on a non-full FIFO leaves occupancy unchanged.
//  Head advances in FIFO order. Pointers wrap modulo FIFO_DEPTH.
//  Lanes drain independently. Lockstep applies to pushes only.
//  dout is the registered head entry. Its value while empty_n=0 is don't-care, 0 after reset.
// STRUCTURE
//  Shared package ntt_stream_pkg holds STREAM_W=65, EOT_BIT=64, and
//   WORDS_PER_POLY, derived as N/(LANES*COEFFS_PER_WORD).
//  Sub-module ntt_stream_fifo (width, depth): synchronous FIFO exposing
//   dout/empty_n/read plus a registered count. Instantiated LANES times via generate.
//  Feeder FSM and word counter live in the top of this module.
// TESTING
//  1. num_polys=1, in_valid held 1, reads held 1 -> 128 words per lane in order, then one
//     word with bit64=1 and data 0 per lane; done pulses exactly once; busy falls after DONE.
//  2. num_polys=0 -> no data is accepted, and in_ready stays 0. EoT appears on all lanes
//     within 2 cycles of start; done pulses.
//  3. Reads held 0 -> after 8 accepts in_ready=0; releasing lane 2 alone keeps in_ready=0.
//     Releasing all lanes resumes with no loss or duplication.
//  4. FIFO at 7 entries with push and pop in the same cycle -> count stays 7.
//     FIFO at 8 entries with pop -> in_ready=0 in that cycle and 1 on the next cycle.
//  5. Reset asserted at word 50 of 128 -> next cycle all empty_n=0, busy=0.
//     A new start streams from word 0.
//  6. start pulsed during STREAM and peek_read toggled randomly -> no effect on
//     counters or FIFO contents.

Source files
------------

// File: rtl/ntt_stream_pkg.sv
// ntt_stream_pkg
//   Shared constants and types for the ntt_core input feeder.
//   STREAM_W / EOT_BIT describe the 65-bit stream word: bit 64 flags
//   end-of-transmission, bits 63:0 carry two 32-bit residues mod q.
//   WORDS_PER_POLY is the number of bus words per transform:
//   N coefficients spread over LANES lanes, COEFFS_PER_WORD per lane word.
package ntt_stream_pkg;

  localparam int LANES           = 4;
  localparam int DATA_W          = 64;
  localparam int STREAM_W        = DATA_W + 1;
  localparam int EOT_BIT         = DATA_W;
  localparam int N               = 1024;
  localparam int COEFFS_PER_WORD = 2;
  localparam int WORDS_PER_POLY  = N / (LANES * COEFFS_PER_WORD);
  localparam int FIFO_DEPTH      = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_EOT,
    ST_DONE
  } feeder_state_t;

endpackage

// File: rtl/ntt_stream_fifo.sv
// ntt_stream_fifo
//   Synchronous FIFO with a dout/empty_n/read stream interface.
//   Ports:
//     clk, reset  - clock, synchronous active-high reset (flushes FIFO)
//     push, din   - write one entry; ignored when full
//     read        - pop the head entry; ignored when empty
//     dout        - head entry taken from registered storage; 0 while empty
//     empty_n     - 1 when at least one entry is held
//     count       - registered occupancy, 0..DEPTH
module ntt_stream_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     read,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty_n,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count != (AW+1)'(DEPTH));
  assign do_pop  = read && (count != '0);
  assign empty_n = (count != '0);

  // Gating with empty_n gives a defined 0 after reset without resetting storage.
  assign dout = empty_n ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ntt_stream_feeder.sv
// ntt_stream_feeder
//   Splits a LANES*DATA_W coefficient bus into one FIFO per ntt_core input lane
//   and appends an end-of-transmission word once the requested number of
//   transforms has been streamed.
//   Ports:
//     clk, reset              - clock, synchronous active-high reset
//     start, num_polys        - launch a job of num_polys transforms (IDLE only)
//     busy, done              - job in progress / one-cycle completion pulse
//     in_data, in_valid,
//     in_ready                - upstream word handshake
//     core_istreams_i_*       - lane i stream: dout, empty_n, read
//     core_istreams_peek_i_*  - non-popping view of lane i; read is ignored
module ntt_stream_feeder
  import ntt_stream_pkg::*;
#(
  parameter int DATA_W         = ntt_stream_pkg::DATA_W,
  parameter int FIFO_DEPTH     = ntt_stream_pkg::FIFO_DEPTH,
  parameter int WORDS_PER_POLY = ntt_stream_pkg::WORDS_PER_POLY
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [31:0]               num_polys,
  output logic                      busy,
  output logic                      done,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W:0]           core_istreams_0_dout,
  output logic                      core_istreams_0_empty_n,
  input  logic                      core_istreams_0_read,
  output logic [DATA_W:0]           core_istreams_1_dout,
  output logic                      core_istreams_1_empty_n,
  input  logic                      core_istreams_1_read,
  output logic [DATA_W:0]           core_istreams_2_dout,
  output logic                      core_istreams_2_empty_n,
  input  logic                      core_istreams_2_read,
  output logic [DATA_W:0]           core_istreams_3_dout,
  output logic                      core_istreams_3_empty_n,
  input  logic                      core_istreams_3_read,
  output logic [DATA_W:0]           core_istreams_peek_0_dout,
  output logic                      core_istreams_peek_0_empty_n,
  input  logic                      core_istreams_peek_0_read,
  output logic [DATA_W:0]           core_istreams_peek_1_dout,
  output logic                      core_istreams_peek_1_empty_n,
  input  logic                      core_istreams_peek_1_read,
  output logic [DATA_W:0]           core_istreams_peek_2_dout,
  output logic                      core_istreams_peek_2_empty_n,
  input  logic                      core_istreams_peek_2_read,
  output logic [DATA_W:0]           core_istreams_peek_3_dout,
  output logic                      core_istreams_peek_3_empty_n,
  input  logic                      core_istreams_peek_3_read
);

  localparam int SW = DATA_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  feeder_state_t state, state_next;
  logic [31:0]   total, total_next;
  logic [31:0]   wcnt, wcnt_next;
  logic [31:0]   total_calc;

  logic             push;
  logic             push_eot;
  logic             space;
  logic [SW-1:0]    lane_dout [LANES];
  logic [LANES-1:0] lane_empty_n;
  logic [LANES-1:0] lane_read;
  logic [LANES-1:0] lane_full;
  logic [CW-1:0]    lane_count [LANES];

  // The peek ports never pop; their read strobes are intentionally dropped.
  logic unused_peek_read;
  assign unused_peek_read = ^{core_istreams_peek_0_read, core_istreams_peek_1_read,
                              core_istreams_peek_2_read, core_istreams_peek_3_read};

  assign lane_read = {core_istreams_3_read, core_istreams_2_read,
                      core_istreams_1_read, core_istreams_0_read};

  // Product wraps mod 2^32 by design.
  assign total_calc = num_polys * 32'(WORDS_PER_POLY);

  // Space is judged on registered occupancy only: a pop in this cycle does
  // not free a slot until the next cycle, keeping in_ready off the read path.
  assign space = ~|lane_full;
  assign busy  = (state != ST_IDLE);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [SW-1:0] push_word;

    assign push_word = push_eot ? {1'b1, {DATA_W{1'b0}}}
                                : {1'b0, in_data[DATA_W*i +: DATA_W]};

    ntt_stream_fifo #(
      .WIDTH (SW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .din     (push_word),
      .read    (lane_read[i]),
      .dout    (lane_dout[i]),
      .empty_n (lane_empty_n[i]),
      .count   (lane_count[i])
    );

    assign lane_full[i] = (lane_count[i] == CW'(FIFO_DEPTH));
  end

  assign core_istreams_0_dout         = lane_dout[0];
  assign core_istreams_1_dout         = lane_dout[1];
  assign core_istreams_2_dout         = lane_dout[2];
  assign core_istreams_3_dout         = lane_dout[3];
  assign core_istreams_0_empty_n      = lane_empty_n[0];
  assign core_istreams_1_empty_n      = lane_empty_n[1];
  assign core_istreams_2_empty_n      = lane_empty_n[2];
  assign core_istreams_3_empty_n      = lane_empty_n[3];
  assign core_istreams_peek_0_dout    = lane_dout[0];
  assign core_istreams_peek_1_dout    = lane_dout[1];
  assign core_istreams_peek_2_dout    = lane_dout[2];
  assign core_istreams_peek_3_dout    = lane_dout[3];
  assign core_istreams_peek_0_empty_n = lane_empty_n[0];
  assign core_istreams_peek_1_empty_n = lane_empty_n[1];
  assign core_istreams_peek_2_empty_n = lane_empty_n[2];
  assign core_istreams_peek_3_empty_n = lane_empty_n[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      total <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_next;
      total <= total_next;
      wcnt  <= wcnt_next;
    end
  end

  always_comb begin
    state_next = state;
    total_next = total;
    wcnt_next  = wcnt;
    in_ready   = 1'b0;
    push       = 1'b0;
    push_eot   = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          total_next = total_calc;
          wcnt_next  = '0;
          state_next = (total_calc == '0) ? ST_EOT : ST_STREAM;
        end
      end
      ST_STREAM: begin
        in_ready = space;
        if (in_valid && space) begin
          push      = 1'b1;
          wcnt_next = wcnt + 32'd1;
          if (wcnt + 32'd1 == total) state_next = ST_EOT;
        end
      end
      ST_EOT: begin
        if (space) begin
          push       = 1'b1;
          push_eot   = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ntt_stream_feeder.sv
// tb_ntt_stream_feeder
//   Directed bench for ntt_stream_feeder. A small model tracks how many words
//   were accepted and popped per lane and derives each expected stream word.
module tb_ntt_stream_feeder;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [31:0]  num_polys = '0;
  logic         busy;
  logic         done;
  logic [255:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [64:0]  dout  [4];
  logic [64:0]  pdout [4];
  logic [3:0]   empty_n;
  logic [3:0]   pempty_n;
  logic [3:0]   rd  = '0;
  logic [3:0]   prd = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int tot      = 0;
  int tx_idx   = 0;
  int rx_idx [4];
  int done_cnt = 0;
  logic ready_seen = 1'b0;

  always #5 clk = ~clk;

  ntt_stream_feeder dut (
    .clk                          (clk),
    .reset                        (reset),
    .start                        (start),
    .num_polys                    (num_polys),
    .busy                         (busy),
    .done                         (done),
    .in_data                      (in_data),
    .in_valid                     (in_valid),
    .in_ready                     (in_ready),
    .core_istreams_0_dout         (dout[0]),
    .core_istreams_0_empty_n      (empty_n[0]),
    .core_istreams_0_read         (rd[0]),
    .core_istreams_1_dout         (dout[1]),
    .core_istreams_1_empty_n      (empty_n[1]),
    .core_istreams_1_read         (rd[1]),
    .core_istreams_2_dout         (dout[2]),
    .core_istreams_2_empty_n      (empty_n[2]),
    .core_istreams_2_read         (rd[2]),
    .core_istreams_3_dout         (dout[3]),
    .core_istreams_3_empty_n      (empty_n[3]),
    .core_istreams_3_read         (rd[3]),
    .core_istreams_peek_0_dout    (pdout[0]),
    .core_istreams_peek_0_empty_n (pempty_n[0]),
    .core_istreams_peek_0_read    (prd[0]),
    .core_istreams_peek_1_dout    (pdout[1]),
    .core_istreams_peek_1_empty_n (pempty_n[1]),
    .core_istreams_peek_1_read    (prd[1]),
    .core_istreams_peek_2_dout    (pdout[2]),
    .core_istreams_peek_2_empty_n (pempty_n[2]),
    .core_istreams_peek_2_read    (prd[2]),
    .core_istreams_peek_3_dout    (pdout[3]),
    .core_istreams_peek_3_empty_n (pempty_n[3]),
    .core_istreams_peek_3_read    (prd[3])
  );

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] payload(input int k, input int lane);
    return {8'(lane), 24'(k), 32'hC0DE_0000 ^ 32'(k * 7)};
  endfunction

  function automatic logic [64:0] exp_word(input int k, input int lane);
    if (k < tot) return {1'b0, payload(k, lane)};
    return {1'b1, 64'd0};
  endfunction

  task automatic clear_model(input int words);
    tot        = words;
    tx_idx     = 0;
    done_cnt   = 0;
    ready_seen = 1'b0;
    for (int i = 0; i < 4; i++) rx_idx[i] = 0;
  endtask

  // Drive one cycle's inputs after the falling edge, then account for the
  // accept/pop events that the next rising edge will perform.
  task automatic tick(input logic st, input logic vld, input logic [3:0] r);
    @(negedge clk);
    start    = st;
    in_valid = vld;
    rd       = r;
    prd      = 4'($urandom);
    for (int i = 0; i < 4; i++) in_data[64*i +: 64] = payload(tx_idx, i);
    #1;
    ready_seen = ready_seen | in_ready;
    if (done) done_cnt++;
    if (in_valid && in_ready) tx_idx++;
    for (int i = 0; i < 4; i++) begin
      if (rd[i] && empty_n[i]) begin
        check_eq($sformatf("lane%0d_word%0d", i, rx_idx[i]), dout[i], exp_word(rx_idx[i], i));
        check_eq($sformatf("peek%0d_word%0d", i, rx_idx[i]), pdout[i], exp_word(rx_idx[i], i));
        rx_idx[i]++;
      end
    end
  endtask

  function automatic logic all_drained();
    for (int i = 0; i < 4; i++) if (rx_idx[i] != tot + 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input string tag);
    int n;
    n = 0;
    while (!(done_cnt > 0 && all_drained()) && n < 2000) begin
      tick(1'b0, 1'b1, 4'hF);
      n++;
    end
    if (n >= 2000) check_eq({tag, "_timeout"}, 65'(n), 65'(0));
    tick(1'b0, 1'b0, 4'h0);
    check_eq({tag, "_accepted"}, 65'(tx_idx), 65'(tot));
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s_popped%0d", tag, i), 65'(rx_idx[i]), 65'(tot + 1));
    check_eq({tag, "_done_once"}, 65'(done_cnt), 65'(1));
    check_eq({tag, "_busy_low"}, 65'(busy), 65'(0));
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rx_idx[i] = 0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_empty_n", 65'(empty_n), 65'(0));
    check_eq("rst_peek_empty_n", 65'(pempty_n), 65'(0));
    check_eq("rst_dout0", dout[0], 65'(0));
    check_eq("rst_dout3", dout[3], 65'(0));
    check_eq("rst_in_ready", 65'(in_ready), 65'(0));
    check_eq("rst_busy", 65'(busy), 65'(0));
    check_eq("rst_done", 65'(done), 65'(0));
    reset = 1'b0;

    // One transform, free-flowing reads.
    clear_model(128);
    num_polys = 32'd1;
    tick(1'b1, 1'b1, 4'hF);
    tick(1'b0, 1'b1, 4'hF);
    check_eq("t1_busy", 65'(busy), 65'(1));
    run_until_done("t1");

    // Zero transforms: EoT only, nothing accepted.
    clear_model(0);
    num_polys = 32'd0;
    tick(1'b1, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b1, 4'h0);
    check_eq("t2_eot_visible", 65'(empty_n), 65'hF);
    check_eq("t2_eot_word", dout[1], {1'b1, 64'd0});
    run_until_done("t2");
    check_eq("t2_ready_never", 65'(ready_seen), 65'(0));

    // Backpressure: all reads held low, then only lane 2 released.
    clear_model(128);
    num_polys = 32'd1;
    tick(1'b1, 1'b1, 4'h0);
    repeat (12) tick(1'b0, 1'b1, 4'h0);
    check_eq("t3_accepts", 65'(tx_idx), 65'(8));
    check_eq("t3_ready_full", 65'(in_ready), 65'(0));
    repeat (10) tick(1'b0, 1'b1, 4'b0100);
    check_eq("t3_ready_lane2", 65'(in_ready), 65'(0));
    check_eq("t3_lane2_popped", 65'(rx_idx[2]), 65'(8));
    check_eq("t3_lane2_empty", 65'(empty_n), 65'b1011);
    check_eq("t3_accepts_hold", 65'(tx_idx), 65'(8));
    run_until_done("t3");

    // Occupancy corners: simultaneous push/pop at 7, pop from full at 8.
    clear_model(128);
    num_polys = 32'd1;
    tick(1'b1, 1'b0, 4'h0);
    for (int n = 0; n < 40 && tx_idx < 7; n++) tick(1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    check_eq("t4_count7", 65'(dut.g_lane[0].u_fifo.count), 65'(7));
    tick(1'b0, 1'b1, 4'hF);
    tick(1'b0, 1'b0, 4'h0);
    check_eq("t4_pushpop_lane0", 65'(dut.g_lane[0].u_fifo.count), 65'(7));
    check_eq("t4_pushpop_lane3", 65'(dut.g_lane[3].u_fifo.count), 65'(7));
    for (int n = 0; n < 40 && tx_idx < 9; n++) tick(1'b0, 1'b1, 4'h0);
    tick(1'b0, 1'b0, 4'h0);
    check_eq("t4_count8", 65'(dut.g_lane[1].u_fifo.count), 65'(8));
    tick(1'b0, 1'b1, 4'hF);
    check_eq("t4_ready_pop_cycle", 65'(in_ready), 65'(0));
    tick(1'b0, 1'b1, 4'h0);
    check_eq("t4_ready_next", 65'(in_ready), 65'(1));
    run_until_done("t4");

    // Reset mid-stream at word 50, then a clean restart.
    clear_model(128);
    num_polys = 32'd1;
    tick(1'b1, 1'b1, 4'hF);
    for (int n = 0; n < 200 && tx_idx < 50; n++) tick(1'b0, 1'b1, 4'hF);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("t5_empty_n", 65'(empty_n), 65'(0));
    check_eq("t5_busy", 65'(busy), 65'(0));
    check_eq("t5_in_ready", 65'(in_ready), 65'(0));
    reset = 1'b0;
    clear_model(128);

    // Restart; a start pulse mid-stream with a different count must be ignored.
    tick(1'b1, 1'b1, 4'hF);
    for (int n = 0; n < 200 && tx_idx < 30; n++) tick(1'b0, 1'b1, 4'hF);
    num_polys = 32'd3;
    tick(1'b1, 1'b1, 4'hF);
    tick(1'b0, 1'b1, 4'hF);
    check_eq("t6_busy", 65'(busy), 65'(1));
    run_until_done("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
